// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_ctrl_pkg
// Description : Shared state encoding and helpers for the layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } seq_state_e;

    // A counter addressing n items needs at least one bit even when n == 1.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // LSB of neuron k inside the packed neuron output bus.
    function automatic int word_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer_if
// Description : Upstream stream, neuron control bus and downstream stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_sequencer_if #(
    parameter int NUM_NEURONS = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = nn_ctrl_pkg::clog2_min1(NUM_NEURONS)
);
    logic [DATA_WIDTH-1:0]             s_data;
    logic                              s_valid;
    logic                              s_ready;
    logic [DATA_WIDTH-1:0]             n_data;
    logic                              n_freeze;
    logic                              n_pause;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] n_out;
    logic [DATA_WIDTH-1:0]             m_data;
    logic [IDX_WIDTH-1:0]              m_index;
    logic                              m_valid;
    logic                              m_ready;
    logic                              m_last;
    logic                              busy;
    logic                              layer_done;

    modport master (
        input  s_data, s_valid, n_out, m_ready,
        output s_ready, n_data, n_freeze, n_pause,
               m_data, m_index, m_valid, m_last, busy, layer_done
    );

    modport slave (
        output s_data, s_valid, n_out, m_ready,
        input  s_ready, n_data, n_freeze, n_pause,
               m_data, m_index, m_valid, m_last, busy, layer_done
    );
endinterface
`default_nettype wire

// File: rtl/layer_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : layer_out_buffer
// Description : Parallel-load bank of neuron outputs, drained one word per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_out_buffer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = clog2_min1(NUM_NEURONS)
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_load,
    input  wire logic [NUM_NEURONS*DATA_WIDTH-1:0] i_bank,
    input  wire logic                              i_en,
    input  wire logic                              i_ready,
    output logic      [DATA_WIDTH-1:0]             o_data,
    output logic      [IDX_WIDTH-1:0]              o_index,
    output logic                                   o_last,
    output logic                                   o_last_hs
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    logic [DATA_WIDTH-1:0] r_bank [NUM_NEURONS];
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  w_hs;
    logic                  w_last;

    // The bank has no reset: it is always overwritten before it is drained.
    always_ff @(posedge clk) begin
        if (i_load) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_bank[k] <= i_bank[word_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    assign w_last = (r_idx == c_LAST_IDX);
    assign w_hs   = i_en & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    assign o_data    = r_bank[r_idx];
    assign o_index   = r_idx;
    assign o_last    = w_last;
    assign o_last_hs = w_hs & w_last;

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Drives one fully-connected layer through accumulate, capture, drain.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_INPUTS  = 784,
    parameter int DATA_WIDTH  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    layer_sequencer_if.master bus
);

    localparam int BEAT_WIDTH = clog2_min1(NUM_INPUTS);
    localparam int IDX_WIDTH  = clog2_min1(NUM_NEURONS);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ACCUM   = ACCUM;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_DRAIN   = DRAIN;

    localparam logic [BEAT_WIDTH-1:0] c_LAST_BEAT = BEAT_WIDTH'(NUM_INPUTS - 1);

    logic [1:0]            r_state;
    logic [BEAT_WIDTH-1:0] r_beat_cnt;
    logic                  r_done;
    logic                  w_s_hs;
    logic                  w_last_hs;
    logic                  w_drain;
    logic [DATA_WIDTH-1:0] w_m_data;
    logic [IDX_WIDTH-1:0]  w_m_index;
    logic                  w_m_last;

    assign w_s_hs  = (r_state == ST_ACCUM) & bus.s_valid;
    assign w_drain = (r_state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            case (r_state)
                ST_IDLE: begin
                    // Entering ACCUM first keeps the beat pending so the
                    // neurons see it with freeze already released.
                    if (bus.s_valid) begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_s_hs) begin
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_beat_cnt <= '0;
                            r_state    <= ST_CAPTURE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_last_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    layer_out_buffer #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_out_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == ST_CAPTURE),
        .i_bank    (bus.n_out),
        .i_en      (w_drain),
        .i_ready   (bus.m_ready),
        .o_data    (w_m_data),
        .o_index   (w_m_index),
        .o_last    (w_m_last),
        .o_last_hs (w_last_hs)
    );

    // Pause tracks s_valid combinationally so only real handshakes accumulate.
    always_comb begin
        bus.s_ready  = (r_state == ST_ACCUM);
        bus.n_freeze = (r_state != ST_ACCUM);
        bus.n_pause  = (r_state == ST_ACCUM) ? ~bus.s_valid : 1'b1;
        bus.n_data   = (r_state == ST_ACCUM) ? bus.s_data : '0;
    end

    assign bus.m_valid    = w_drain;
    assign bus.m_data     = w_m_data;
    assign bus.m_index    = w_m_index;
    assign bus.m_last     = w_drain & w_m_last;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.layer_done = r_done;

endmodule
`default_nettype wire
